// File: rtl/tomasulo_pkg.sv
// ============================================================================
// tomasulo_pkg : shared types for the ALU reservation station
// Rev 1.0
// ============================================================================
`default_nettype none

package tomasulo_pkg;

    localparam int RS_TAG_W  = 4;
    localparam int RS_OP_W   = 5;
    localparam int RS_DATA_W = 64;
    localparam int RS_HW_W   = 6;

    typedef logic [RS_TAG_W-1:0] tag_t;

    typedef enum logic [RS_OP_W-1:0] {
        PLUS_OP  = 5'd0,
        MINUS_OP = 5'd1,
        AND_OP   = 5'd2,
        OR_OP    = 5'd3,
        XOR_OP   = 5'd4
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        RESULT = 2'd2
    } issue_state_t;

    typedef struct packed {
        logic                 valid;
        alu_op_t              op;
        tag_t                 dst_tag;
        logic                 a_rdy;
        logic [RS_DATA_W-1:0] a_val;
        tag_t                 a_tag;
        logic                 b_rdy;
        logic [RS_DATA_W-1:0] b_val;
        tag_t                 b_tag;
        logic [RS_HW_W-1:0]   hw;
    } rs_entry_t;

endpackage

`default_nettype wire

// File: rtl/rs_select.sv
// ============================================================================
// rs_select : lowest-index priority picker (free-slot and ready-entry select)
// Rev 1.0
// ============================================================================
`default_nettype none

module rs_select #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Scan downward so the lowest set bit is the last one assigned.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = i[IDX_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_issue_station.sv
// ============================================================================
// alu_issue_station : Tomasulo reservation station issuing one ALU op at a time
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_issue_station
    import tomasulo_pkg::*;
#(
    parameter int ENTRIES = 4,
    parameter int TAG_W   = 4,
    parameter int OP_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [OP_W-1:0]  disp_op,
    input  logic [TAG_W-1:0] disp_dst_tag,
    input  logic             disp_a_rdy,
    input  logic             disp_b_rdy,
    input  logic [63:0]      disp_a_val,
    input  logic [63:0]      disp_b_val,
    input  logic [TAG_W-1:0] disp_a_tag,
    input  logic [TAG_W-1:0] disp_b_tag,
    input  logic [5:0]       disp_hw,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [63:0]      cdb_val,
    output logic             alu_start,
    output logic [OP_W-1:0]  alu_op,
    output logic [63:0]      alu_vala,
    output logic [63:0]      alu_valb,
    output logic [5:0]       alu_valhw,
    input  logic [63:0]      alu_res,
    input  logic             alu_done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [TAG_W-1:0] res_tag,
    output logic [63:0]      res_val
);

    localparam int C_IDX_W = $clog2(ENTRIES);

    rs_entry_t           r_rs [ENTRIES];
    issue_state_t        r_state;
    logic [TAG_W-1:0]    r_tag;

    logic [ENTRIES-1:0]  w_free_mask;
    logic [ENTRIES-1:0]  w_rdy_mask;
    logic                w_free_found;
    logic                w_rdy_found;
    logic [C_IDX_W-1:0]  w_free_idx;
    logic [C_IDX_W-1:0]  w_rdy_idx;
    logic                w_dispatch;
    logic                w_issue;
    rs_entry_t           w_new_entry;

    for (genvar g = 0; g < ENTRIES; g++) begin : g_mask
        assign w_free_mask[g] = ~r_rs[g].valid;
        assign w_rdy_mask[g]  = r_rs[g].valid & r_rs[g].a_rdy & r_rs[g].b_rdy;
    end

    rs_select #(.N(ENTRIES)) u_free_sel (
        .req   (w_free_mask),
        .found (w_free_found),
        .idx   (w_free_idx)
    );

    rs_select #(.N(ENTRIES)) u_rdy_sel (
        .req   (w_rdy_mask),
        .found (w_rdy_found),
        .idx   (w_rdy_idx)
    );

    assign disp_ready = w_free_found;
    assign w_dispatch = disp_valid & w_free_found;
    assign w_issue    = (r_state == IDLE) & w_rdy_found;

    // New entry, with operands resolved directly from a same-cycle CDB broadcast.
    always_comb begin
        w_new_entry         = '0;
        w_new_entry.valid   = 1'b1;
        w_new_entry.op      = alu_op_t'(disp_op);
        w_new_entry.dst_tag = tag_t'(disp_dst_tag);
        w_new_entry.a_rdy   = disp_a_rdy;
        w_new_entry.a_val   = disp_a_val;
        w_new_entry.a_tag   = tag_t'(disp_a_tag);
        w_new_entry.b_rdy   = disp_b_rdy;
        w_new_entry.b_val   = disp_b_val;
        w_new_entry.b_tag   = tag_t'(disp_b_tag);
        w_new_entry.hw      = disp_hw;
        if (cdb_valid && !disp_a_rdy && (disp_a_tag == cdb_tag)) begin
            w_new_entry.a_rdy = 1'b1;
            w_new_entry.a_val = cdb_val;
        end
        if (cdb_valid && !disp_b_rdy && (disp_b_tag == cdb_tag)) begin
            w_new_entry.b_rdy = 1'b1;
            w_new_entry.b_val = cdb_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_rs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (cdb_valid && r_rs[i].valid) begin
                    if (!r_rs[i].a_rdy && (r_rs[i].a_tag == tag_t'(cdb_tag))) begin
                        r_rs[i].a_rdy <= 1'b1;
                        r_rs[i].a_val <= cdb_val;
                    end
                    if (!r_rs[i].b_rdy && (r_rs[i].b_tag == tag_t'(cdb_tag))) begin
                        r_rs[i].b_rdy <= 1'b1;
                        r_rs[i].b_val <= cdb_val;
                    end
                end
            end
            // Dispatch targets a free slot and issue frees a valid one, so they never collide.
            if (w_dispatch) begin
                r_rs[w_free_idx] <= w_new_entry;
            end
            if (w_issue) begin
                r_rs[w_rdy_idx].valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_tag     <= '0;
            alu_start <= 1'b0;
            alu_op    <= '0;
            alu_vala  <= '0;
            alu_valb  <= '0;
            alu_valhw <= '0;
            res_valid <= 1'b0;
            res_tag   <= '0;
            res_val   <= '0;
        end else begin
            alu_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        alu_start <= 1'b1;
                        alu_op    <= OP_W'(r_rs[w_rdy_idx].op);
                        alu_vala  <= r_rs[w_rdy_idx].a_val;
                        alu_valb  <= r_rs[w_rdy_idx].b_val;
                        alu_valhw <= r_rs[w_rdy_idx].hw;
                        r_tag     <= TAG_W'(r_rs[w_rdy_idx].dst_tag);
                        r_state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (alu_done) begin
                        res_valid <= 1'b1;
                        res_tag   <= r_tag;
                        res_val   <= alu_res;
                        r_state   <= RESULT;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_station.sv
// ============================================================================
// tb_alu_issue_station : directed self-checking bench for alu_issue_station
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_issue_station;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        disp_valid = 1'b0;
    logic        disp_ready;
    logic [4:0]  disp_op = '0;
    logic [3:0]  disp_dst_tag = '0;
    logic        disp_a_rdy = 1'b0;
    logic        disp_b_rdy = 1'b0;
    logic [63:0] disp_a_val = '0;
    logic [63:0] disp_b_val = '0;
    logic [3:0]  disp_a_tag = '0;
    logic [3:0]  disp_b_tag = '0;
    logic [5:0]  disp_hw = '0;
    logic        cdb_valid = 1'b0;
    logic [3:0]  cdb_tag = '0;
    logic [63:0] cdb_val = '0;
    logic        alu_start;
    logic [4:0]  alu_op;
    logic [63:0] alu_vala;
    logic [63:0] alu_valb;
    logic [5:0]  alu_valhw;
    logic [63:0] alu_res = '0;
    logic        alu_done = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [3:0]  res_tag;
    logic [63:0] res_val;

    int n_vec  = 0;
    int n_miss = 0;

    alu_issue_station #(.ENTRIES(4), .TAG_W(4), .OP_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .disp_valid   (disp_valid),
        .disp_ready   (disp_ready),
        .disp_op      (disp_op),
        .disp_dst_tag (disp_dst_tag),
        .disp_a_rdy   (disp_a_rdy),
        .disp_b_rdy   (disp_b_rdy),
        .disp_a_val   (disp_a_val),
        .disp_b_val   (disp_b_val),
        .disp_a_tag   (disp_a_tag),
        .disp_b_tag   (disp_b_tag),
        .disp_hw      (disp_hw),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_val      (cdb_val),
        .alu_start    (alu_start),
        .alu_op       (alu_op),
        .alu_vala     (alu_vala),
        .alu_valb     (alu_valb),
        .alu_valhw    (alu_valhw),
        .alu_res      (alu_res),
        .alu_done     (alu_done),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_tag      (res_tag),
        .res_val      (res_val)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input logic [4:0] op, input logic [3:0] dst,
                            input logic ar, input logic [63:0] av, input logic [3:0] at,
                            input logic br, input logic [63:0] bv, input logic [3:0] bt);
        disp_valid   = 1'b1;
        disp_op      = op;
        disp_dst_tag = dst;
        disp_a_rdy   = ar;
        disp_a_val   = av;
        disp_a_tag   = at;
        disp_b_rdy   = br;
        disp_b_val   = bv;
        disp_b_tag   = bt;
        disp_hw      = 6'd0;
        tick();
        disp_valid   = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            if (alu_start) seen = 1'b1;
        end
        check_eq({tag, "_start_seen"}, {63'd0, seen}, 64'd1);
    endtask

    // Execute-unit model: answer two cycles after start, then accept on the CDB.
    task automatic complete(input string tag, input logic [63:0] res, input logic [3:0] exp_tag);
        tick();
        check_eq({tag, "_start_one_cycle"}, {63'd0, alu_start}, 64'd0);
        alu_done = 1'b1;
        alu_res  = res;
        tick();
        alu_done = 1'b0;
        check_eq({tag, "_res_valid"}, {63'd0, res_valid}, 64'd1);
        check_eq({tag, "_res_tag"}, {60'd0, res_tag}, {60'd0, exp_tag});
        check_eq({tag, "_res_val"}, res_val, res);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check_eq({tag, "_res_cleared"}, {63'd0, res_valid}, 64'd0);
    endtask

    initial begin
        logic        stable;
        logic        started;
        logic [63:0] ones;
        ones = 64'hFFFF_FFFF_FFFF_FFFF;

        // Reset state
        repeat (2) tick();
        check_eq("rst_disp_ready", {63'd0, disp_ready}, 64'd1);
        check_eq("rst_alu_start", {63'd0, alu_start}, 64'd0);
        check_eq("rst_res_valid", {63'd0, res_valid}, 64'd0);
        check_eq("rst_res_val", res_val, 64'd0);
        rst = 1'b1;
        tick();

        // Both operands ready: PLUS 1+1
        dispatch(5'd0, 4'd3, 1'b1, 64'd1, 4'd0, 1'b1, 64'd1, 4'd0);
        check_eq("t1_no_early_start", {63'd0, alu_start}, 64'd0);
        tick();
        check_eq("t1_start", {63'd0, alu_start}, 64'd1);
        check_eq("t1_op", {59'd0, alu_op}, 64'd0);
        check_eq("t1_vala", alu_vala, 64'd1);
        check_eq("t1_valb", alu_valb, 64'd1);
        complete("t1", 64'd2, 4'd3);

        // Operand B pending on tag 5, woken by CDB
        dispatch(5'd1, 4'd7, 1'b1, ones, 4'd0, 1'b0, 64'd0, 4'd5);
        started = 1'b0;
        repeat (3) begin
            tick();
            started |= alu_start;
        end
        check_eq("t2_no_start_pending", {63'd0, started}, 64'd0);
        cdb_valid = 1'b1;
        cdb_tag   = 4'd5;
        cdb_val   = 64'd1;
        tick();
        cdb_valid = 1'b0;
        check_eq("t2_no_start_on_cdb_edge", {63'd0, alu_start}, 64'd0);
        tick();
        check_eq("t2_start_next", {63'd0, alu_start}, 64'd1);
        check_eq("t2_op", {59'd0, alu_op}, 64'd1);
        check_eq("t2_vala", alu_vala, ones);
        check_eq("t2_valb", alu_valb, 64'd1);
        complete("t2", ones - 64'd1, 4'd7);

        // Same-cycle dispatch bypass from the CDB
        cdb_valid = 1'b1;
        cdb_tag   = 4'd9;
        cdb_val   = 64'h55;
        dispatch(5'd0, 4'd2, 1'b1, 64'd10, 4'd0, 1'b0, 64'd0, 4'd9);
        cdb_valid = 1'b0;
        check_eq("t3_no_early_start", {63'd0, alu_start}, 64'd0);
        tick();
        check_eq("t3_start", {63'd0, alu_start}, 64'd1);
        check_eq("t3_valb_bypass", alu_valb, 64'h55);
        complete("t3", 64'h5F, 4'd2);

        // Fill the station with pending ops, then overflow
        for (int i = 0; i < 4; i++) begin
            dispatch(5'd0, 4'(i), 1'b1, 64'(i + 1), 4'd0, 1'b0, 64'd0, 4'd12);
        end
        check_eq("t4_full_disp_ready", {63'd0, disp_ready}, 64'd0);
        dispatch(5'd0, 4'd15, 1'b1, 64'd99, 4'd0, 1'b1, 64'd99, 4'd0);
        check_eq("t4_still_full", {63'd0, disp_ready}, 64'd0);
        check_eq("t4_no_start_full", {63'd0, alu_start}, 64'd0);
        cdb_valid = 1'b1;
        cdb_tag   = 4'd12;
        cdb_val   = 64'd100;
        tick();
        cdb_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_start("t4");
            if (i == 0) check_eq("t4_free_after_issue", {63'd0, disp_ready}, 64'd1);
            check_eq("t4_order_vala", alu_vala, 64'(i + 1));
            check_eq("t4_valb", alu_valb, 64'd100);
            complete("t4", 64'(i + 101), 4'(i));
        end
        started = 1'b0;
        repeat (6) begin
            tick();
            started |= alu_start;
        end
        check_eq("t4_overflow_dropped", {63'd0, started}, 64'd0);

        // Back-pressure in RESULT with another ready op waiting
        dispatch(5'd0, 4'd4, 1'b1, 64'd5, 4'd0, 1'b1, 64'd6, 4'd0);
        dispatch(5'd0, 4'd5, 1'b1, 64'd7, 4'd0, 1'b1, 64'd8, 4'd0);
        check_eq("t5_start", {63'd0, alu_start}, 64'd1);
        check_eq("t5_vala", alu_vala, 64'd5);
        tick();
        alu_done = 1'b1;
        alu_res  = 64'd11;
        tick();
        alu_done = 1'b0;
        stable  = 1'b1;
        started = 1'b0;
        for (int i = 0; i < 5; i++) begin
            alu_done = (i == 1);
            alu_res  = (i == 1) ? 64'hDEAD : 64'd0;
            tick();
            stable  &= res_valid && (res_tag == 4'd4) && (res_val == 64'd11);
            started |= alu_start;
        end
        alu_done = 1'b0;
        check_eq("t5_res_stable", {63'd0, stable}, 64'd1);
        check_eq("t5_no_issue_in_result", {63'd0, started}, 64'd0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check_eq("t5_accepted", {63'd0, res_valid}, 64'd0);
        wait_start("t5b");
        check_eq("t5b_vala", alu_vala, 64'd7);
        complete("t5b", 64'd15, 4'd5);

        // Asynchronous reset while BUSY
        dispatch(5'd0, 4'd6, 1'b1, 64'd1, 4'd0, 1'b1, 64'd2, 4'd0);
        wait_start("t6");
        tick();
        #2;
        rst = 1'b0;
        #1;
        check_eq("t6_async_alu_start", {63'd0, alu_start}, 64'd0);
        check_eq("t6_async_vala", alu_vala, 64'd0);
        check_eq("t6_async_disp_ready", {63'd0, disp_ready}, 64'd1);
        tick();
        rst = 1'b1;
        alu_done = 1'b1;
        alu_res  = 64'd5;
        tick();
        alu_done = 1'b0;
        tick();
        check_eq("t6_res_valid", {63'd0, res_valid}, 64'd0);
        check_eq("t6_res_val", res_val, 64'd0);
        check_eq("t6_alu_start", {63'd0, alu_start}, 64'd0);
        check_eq("t6_disp_ready", {63'd0, disp_ready}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
